// File: rtl/comparator_search_pkg.sv
// ============================================================================
// Package : comparator_search_pkg
// Purpose : Shared definitions for comparator-facing blocks. It provides the
//           search FSM state encoding, the bit positions of the
//           LT/EQ/GT comparator flags when they are packed into a vector,
//           and a one-hot test for that flag vector.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package comparator_search_pkg;

    // Search FSM state encoding
    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_SEARCH = 1'b1
    } state_t;

    // Bit positions of the comparator flags within a packed flag vector
    localparam int CMP_LT     = 0;
    localparam int CMP_EQ     = 1;
    localparam int CMP_GT     = 2;
    localparam int CMP_NFLAGS = 3;

    // A well-behaved comparator raises exactly one flag
    function automatic logic is_onehot3(input logic [CMP_NFLAGS-1:0] f);
        return (f == 3'b001) || (f == 3'b010) || (f == 3'b100);
    endfunction

endpackage

`default_nettype wire

// File: rtl/comparator_search.sv
// ============================================================================
// Module  : comparator_search
// Purpose : Binary-search initiator for an external magnitude comparator.
//           It drives the comparator's B operand with the midpoint of the
//           current [lo, hi] window. It then narrows the window from the
//           returned flags until it finds the hidden operand A.
// Ports   : clk    - rising-edge clock
//           rst_n  - asynchronous active-low reset
//           START  - begin a search (sampled only in IDLE)
//           ALTB   - comparator flag A <  PROBE
//           AEQB   - comparator flag A == PROBE
//           AGTB   - comparator flag A >  PROBE
//           PROBE  - value driven onto comparator B (0 outside SEARCH)
//           BUSY   - high while searching
//           DONE   - one-cycle pulse when a search ends (match or error)
//           RESULT - recovered A (0 on error), held until the next START
//           ERROR  - last search failed, held until the next START
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module comparator_search
    import comparator_search_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             START,
    input  logic             ALTB,
    input  logic             AEQB,
    input  logic             AGTB,
    output logic [WIDTH-1:0] PROBE,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] RESULT,
    output logic             ERROR
);

    // Top of the search range, held at the widened bound width
    localparam logic [WIDTH:0] MAX_VAL = {1'b0, {WIDTH{1'b1}}};

    state_t            state, state_d;
    logic [WIDTH:0]    lo, hi, lo_d, hi_d;
    logic [WIDTH:0]    sum, mid;
    logic              busy_d, done_d, error_d, fail;
    logic [WIDTH-1:0]  result_d;
    logic [CMP_NFLAGS-1:0] flags;

    // Bounds carry one spare bit so that lo+hi cannot overflow
    assign sum = lo + hi;
    assign mid = sum >> 1;

    // PROBE depends only on registered state, so it has no path from the flags
    assign PROBE = (state == S_SEARCH) ? mid[WIDTH-1:0] : '0;

    always_comb begin
        flags         = '0;
        flags[CMP_LT] = ALTB;
        flags[CMP_EQ] = AEQB;
        flags[CMP_GT] = AGTB;
    end

    always_comb begin
        state_d  = state;
        lo_d     = lo;
        hi_d     = hi;
        done_d   = 1'b0;
        result_d = RESULT;
        error_d  = ERROR;
        fail     = 1'b0;

        case (state)
            S_IDLE: begin
                if (START) begin
                    lo_d    = '0;
                    hi_d    = MAX_VAL;
                    error_d = 1'b0;
                    state_d = S_SEARCH;
                end
            end
            S_SEARCH: begin
                if (!is_onehot3(flags)) begin
                    fail = 1'b1;
                end else if (flags[CMP_EQ]) begin
                    result_d = mid[WIDTH-1:0];
                    done_d   = 1'b1;
                    state_d  = S_IDLE;
                end else if (flags[CMP_LT]) begin
                    // Refuse to step below zero or past the lower bound
                    if ((mid == '0) || ((mid - 1'b1) < lo)) begin
                        fail = 1'b1;
                    end else begin
                        hi_d = mid - 1'b1;
                    end
                end else begin
                    // Refuse to step above the range top or past the upper bound
                    if ((mid == MAX_VAL) || ((mid + 1'b1) > hi)) begin
                        fail = 1'b1;
                    end else begin
                        lo_d = mid + 1'b1;
                    end
                end

                if (fail) begin
                    error_d  = 1'b1;
                    result_d = '0;
                    done_d   = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d == S_SEARCH);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            lo     <= '0;
            hi     <= '0;
            BUSY   <= 1'b0;
            DONE   <= 1'b0;
            RESULT <= '0;
            ERROR  <= 1'b0;
        end else begin
            state  <= state_d;
            lo     <= lo_d;
            hi     <= hi_d;
            BUSY   <= busy_d;
            DONE   <= done_d;
            RESULT <= result_d;
            ERROR  <= error_d;
        end
    end

endmodule

`default_nettype wire
